// File: rtl/pipeline_elastic.sv
// -----------------------------------------------------------------------------
// pipeline_elastic
//
// Delay pipeline of LATENCY register stages with per-stage valid/ready flow
// control. Every stage holds one beat. A stage can take a new beat when it is
// empty or when the stage after it is passing its own beat on in the same
// cycle. Bubbles therefore collapse under stall, and an unstalled pipeline
// moves one beat per cycle.
//
// Optional feature (compile-time macro):
//   PIPELINE_FLUSH_EN - adds the flush_i port. At a clock edge, flush_i clears
//                       every valid bit and the occupancy count. Data registers
//                       keep their contents.
// -----------------------------------------------------------------------------
module pipeline_elastic #(
  parameter  int LATENCY    = 3,
  parameter  int BUFF_WIDTH = 32,
  localparam int CNT_W      = $clog2(LATENCY + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  valid_i,
  input  logic [BUFF_WIDTH-1:0] data_i,
  output logic                  ready_o,
  output logic                  valid_o,
  output logic [BUFF_WIDTH-1:0] data_o,
  input  logic                  ready_i,
  output logic [CNT_W-1:0]      count_o
`ifdef PIPELINE_FLUSH_EN
  ,
  input  logic                  flush_i
`endif
);

  // Per-stage state. Stage 0 faces the input and stage LATENCY-1 drives the output.
  logic [LATENCY-1:0]    v;
  logic [LATENCY-1:0]    r;
  logic [BUFF_WIDTH-1:0] d [LATENCY];

  logic in_fire;
  logic out_fire;

  // Stage readiness, computed combinationally from the output stage back to stage 0.
  // r[k] = !v[k] | r[k+1] reduces to "ready_i, or at least one empty stage
  // at index k or above". A running AND over the valid bits keeps the chain
  // free of self-referencing bits in r.
  always_comb begin
    logic all_full;
    // NOTE: give every combinational output a default value first. A path
    // that leaves a variable unassigned infers a latch.
    r        = '0;
    all_full = 1'b1;
    for (int k = LATENCY - 1; k >= 0; k--) begin
      all_full = all_full & v[k];
      r[k]     = ready_i | ~all_full;
    end
  end

  assign ready_o  = r[0];
  assign valid_o  = v[LATENCY-1];
  assign data_o   = d[LATENCY-1];
  assign in_fire  = valid_i & r[0];
  assign out_fire = v[LATENCY-1] & ready_i;

  // Valid bits. A ready stage takes the valid bit of the stage before it,
  // which clears the stage when that stage is empty. A stalled stage holds.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // NOTE: sequential state is updated with non-blocking assignments only.
      // Every stage then samples the values from before the edge, so a beat
      // moves exactly one stage per clock.
      v <= '0;
    end
`ifdef PIPELINE_FLUSH_EN
    else if (flush_i) begin
      v <= '0;
    end
`endif
    else begin
      if (r[0]) v[0] <= valid_i;
      for (int k = 1; k < LATENCY; k++) begin
        if (r[k]) v[k] <= v[k-1];
      end
    end
  end

  // Data registers. They load only when a real beat enters the stage, so a
  // stalled or emptied stage keeps its last value.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // NOTE: these are individual pipeline registers, not a RAM. The output
      // must read zero after reset, so every one of them is reset.
      for (int k = 0; k < LATENCY; k++) d[k] <= '0;
    end else begin
      if (in_fire) d[0] <= data_i;
      for (int k = 1; k < LATENCY; k++) begin
        if (v[k-1] && r[k]) d[k] <= d[k-1];
      end
    end
  end

  // Occupancy count. It moves only when exactly one side of the block
  // transfers a beat. Flush empties the pipeline, so the count returns to 0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_o <= '0;
    end
`ifdef PIPELINE_FLUSH_EN
    else if (flush_i) begin
      count_o <= '0;
    end
`endif
    else begin
      case ({in_fire, out_fire})
        2'b10:   count_o <= count_o + CNT_W'(1);
        2'b01:   count_o <= count_o - CNT_W'(1);
        default: count_o <= count_o;
      endcase
    end
  end

endmodule
